sprite_motion_block: RTL and testbench
======================================

# sprite_motion_block

Parametrised ROM-backed sprite renderer for the VGA compositor, successor to the fixed-size arm block renderers. It compares the scan position against a movable bounding box and fetches the texel from a sprite ROM. It emits a layer-tagged RGB pixel with a key-colour transparency test, pipeline-aligned to the scan coordinates. A frame-synchronous motion FSM oscillates the sprite along a diagonal and can return it to its home position on command.

## Interface
- SPRITE_W, 31: sprite width in pixels (1..640)
- SPRITE_H, 69: sprite height in pixels (1..480)
- X_INIT, 280: home top-left X
- Y_INIT, 240: home top-left Y
- LAYER, 1: 6-bit layer ID reported with valid pixels
- KEY_COLOR, 24'h000000: transparent texel value
- DX, 1 / DY, 1: per-step displacement magnitudes
- STEP_DIV, 8: frames per motion step (>=1)
- SWING_STEPS, 8: steps per direction before reversal (>=1)
- clk  input  1  pixel-domain clock
- reset  input  1  asynchronous, active-low
- enable  input  1  render enable; low forces oVal=0 (pipeline still advances)
- motion_en  input  1  motion FSM advance enable; low freezes position, counters and state
- iHome  input  1  single-cycle request to return to (X_INIT,Y_INIT)
- iVGA_X  input  10  scan X
- iVGA_Y  input  9  scan Y
- oLayer  output  6  LAYER when oVal, else 0
- oVal  output  1  pixel valid (inside box, non-key, enabled)
- R, G, B  output  8 each  pixel colour
- oPosX  output  10 / oPosY  output  9  current top-left
- oFrameTick  output  1  one-cycle pulse at each detected frame start

## Operation
- Hit test, inclusive: posX <= X < posX+SPRITE_W and posY <= Y < posY+SPRITE_H, computed in 11/10 bits so no wrap near the right/bottom edges; boxes partially off-screen clip naturally.
- Address: SPRITE_W*(Y-posY) + (X-posX), width ADDR_W = clog2(SPRITE_W*SPRITE_H). Applied to ROM only on hit; otherwise address holds.
- Transparency: q == KEY_COLOR gives oVal=0. R/G/B update only when oVal goes/stays 1, and hold otherwise.
- Frame start: rising detection of (X==0 && Y==0). This gives exactly one tick per frame, even if coordinates dwell many cycles.
- Motion FSM states:
  - FWD: every STEP_DIV ticks, step (+DX, -DY); after SWING_STEPS steps, go to REV and clear the step count.
  - REV: every STEP_DIV ticks, step (-DX, +DY); after SWING_STEPS steps, go to FWD.
  - RETURN: every tick, move each axis by up to DX/DY toward home. When exactly home, go to FWD with counters cleared.
- iHome is accepted in any state, including while motion_en is low. It is latched and acted on at the next tick with motion_en high. iHome while already in RETURN has no effect.
- Position changes only on a tick, so no intra-frame tearing.
- Reset:
  - posX=X_INIT, posY=Y_INIT, state FWD, counters 0.
  - oVal=0, oLayer=0, R=G=B=0, oFrameTick=0.

## Timing
- Render latency 2 cycles: coordinates at cycle N give a registered output at N+2. The ROM registers its address, so q is valid at N+1; the hit/enable flags are delayed one stage to match.
- enable is sampled with the coordinates at N, not at output time.
- oFrameTick is asserted the cycle after (0,0) is first seen. The position update is visible on oPosX/oPosY in that same cycle.
- Ticks arriving while motion_en is low are ignored and do not count.

## Structure
- Shared package sprite_pkg: motion state enum (FWD, REV, RETURN), RGB 24-bit type, layer width constant, clog2 helper.
- Sub-module sprite_rom: single-port synchronous ROM (registered address, 1-cycle read), parametrised by depth, width 24 and init file.
- The motion FSM stays in-line; no separate module.

## Test plan
- Stationary render: motion_en=0, scan (280,240) -> 2 cycles later oVal=1, RGB=ROM[0]. Scan (279,240) and (311,240) -> oVal=0. Scan (310,308) -> ROM[2138].
- Key colour: ROM word 24'h000000 at addr 5, scan (285,240) -> oVal=0, RGB holds the previous value.
- Oscillation: STEP_DIV=2, SWING_STEPS=3, 12 frames -> positions (281,239),(282,238),(283,237), then (282,238),(281,239),(280,240). FWD→REV reversal happens at step 3.
- Home: after 2 FWD steps, pulse iHome -> one tick later pos=(281,239); next tick (280,240), state FWD, counters 0.
- Frame detect: hold (0,0) for 5 cycles -> exactly one oFrameTick.
- Async reset mid-frame: assert reset while oVal=1 -> outputs 0 immediately, pos=(280,240); rendering resumes with correct 2-cycle latency after release.

Source files
------------

// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite renderer: motion states, the RGB
// texel type, the layer ID width, a ceiling-log2 helper and the sprite artwork.
package sprite_pkg;

  localparam int LAYER_W = 6;
  localparam int RGB_W   = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  typedef enum logic [1:0] {
    FWD    = 2'd0,
    REV    = 2'd1,
    RETURN = 2'd2
  } motion_state_e;

  // Ceiling log2, clamped to at least 1 so a one-entry ROM still has an address bit.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Sprite artwork as a closed-form pattern: every word whose low six address
  // bits equal 5 is black (the default key colour); every other word has a
  // non-zero blue channel.
  function automatic rgb_t sprite_texel(input logic [15:0] addr);
    if (addr[5:0] == 6'd5) begin
      return '0;
    end
    return {addr[7:0], addr[15:8] ^ 8'hA5, 8'hC3};
  endfunction

endpackage

// File: rtl/sprite_rom.sv
// Single-port synchronous sprite ROM: the address is registered and the
// texel for that registered address is presented one cycle later.
module sprite_rom
  import sprite_pkg::*;
#(
  parameter int DEPTH  = 2139,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              addr_en,
  input  logic [ADDR_W-1:0] addr,
  output rgb_t              q
);

  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_q;

  // Load a new address only when enabled; otherwise keep the last one.
  always_comb begin
    addr_d = addr_q;
    if (addr_en) begin
      addr_d = addr;
    end
  end

  // Address register (asynchronous active-low reset).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Read the artwork at the registered address; reads past the end are blank.
  always_comb begin
    q = '0;
    if (int'(addr_q) < DEPTH) begin
      q = sprite_texel(16'(addr_q));
    end
  end

endmodule

// File: rtl/sprite_motion_block.sv
// ROM-backed sprite renderer with a frame-synchronous diagonal motion FSM.
// The render path is two cycles deep: the box test and ROM address register at
// the first edge, and the keyed pixel registers at the second.
module sprite_motion_block
  import sprite_pkg::*;
#(
  parameter int                 SPRITE_W    = 31,
  parameter int                 SPRITE_H    = 69,
  parameter int                 X_INIT      = 280,
  parameter int                 Y_INIT      = 240,
  parameter logic [LAYER_W-1:0] LAYER       = 6'd1,
  parameter rgb_t               KEY_COLOR   = 24'h000000,
  parameter int                 DX          = 1,
  parameter int                 DY          = 1,
  parameter int                 STEP_DIV    = 8,
  parameter int                 SWING_STEPS = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               motion_en,
  input  logic               iHome,
  input  logic [9:0]         iVGA_X,
  input  logic [8:0]         iVGA_Y,
  output logic [LAYER_W-1:0] oLayer,
  output logic               oVal,
  output logic [7:0]         R,
  output logic [7:0]         G,
  output logic [7:0]         B,
  output logic [9:0]         oPosX,
  output logic [8:0]         oPosY,
  output logic               oFrameTick
);

  localparam int DEPTH  = SPRITE_W * SPRITE_H;
  localparam int ADDR_W = clog2(DEPTH);
  localparam int DIV_W  = clog2(STEP_DIV + 1);
  localparam int STEP_W = clog2(SWING_STEPS + 1);

  localparam logic [9:0]        HOME_X    = 10'(X_INIT);
  localparam logic [8:0]        HOME_Y    = 9'(Y_INIT);
  localparam logic [9:0]        STEP_X    = 10'(DX);
  localparam logic [8:0]        STEP_Y    = 9'(DY);
  localparam logic [DIV_W-1:0]  LAST_DIV  = DIV_W'(STEP_DIV - 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(SWING_STEPS - 1);

  // Render pipeline state
  logic              hit;
  logic [ADDR_W-1:0] rom_addr;
  rgb_t              rom_q;
  logic              hit_d,  hit_q;
  logic              en_d,   en_q;
  logic              val_d,  val_q;
  rgb_t              rgb_d,  rgb_q;

  // Frame detection state
  logic              origin_d, origin_q;
  logic              tick_d,   tick_q;

  // Motion state
  motion_state_e     state_d,     state_q;
  logic [DIV_W-1:0]  div_cnt_d,   div_cnt_q;
  logic [STEP_W-1:0] step_cnt_d,  step_cnt_q;
  logic [9:0]        pos_x_d,     pos_x_q;
  logic [8:0]        pos_y_d,     pos_y_q;
  logic              home_pend_d, home_pend_q;

  // Box test and ROM address, widened by one bit so box edges never wrap.
  always_comb begin
    logic [10:0] scan_x, box_x0, box_x1, off_x;
    logic [9:0]  scan_y, box_y0, box_y1, off_y;
    scan_x   = {1'b0, iVGA_X};
    scan_y   = {1'b0, iVGA_Y};
    box_x0   = {1'b0, pos_x_q};
    box_y0   = {1'b0, pos_y_q};
    box_x1   = box_x0 + 11'(SPRITE_W);
    box_y1   = box_y0 + 10'(SPRITE_H);
    off_x    = scan_x - box_x0;
    off_y    = scan_y - box_y0;
    hit      = (scan_x >= box_x0) && (scan_x < box_x1) &&
               (scan_y >= box_y0) && (scan_y < box_y1);
    rom_addr = ADDR_W'(32'(SPRITE_W) * 32'(off_y) + 32'(off_x));
  end

  sprite_rom #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_rom (
    .clk     (clk),
    .reset   (reset),
    .addr_en (hit),
    .addr    (rom_addr),
    .q       (rom_q)
  );

  // Stage 1 delays hit/enable alongside the ROM read; stage 2 applies the key
  // test and holds the colour whenever the pixel is not shown.
  always_comb begin
    hit_d = hit;
    en_d  = enable;
    val_d = hit_q && en_q && (rom_q != KEY_COLOR);
    rgb_d = val_d ? rom_q : rgb_q;
  end

  // Frame start is the first cycle the scan sits at the origin.
  always_comb begin
    origin_d = (iVGA_X == 10'd0) && (iVGA_Y == 9'd0);
    tick_d   = origin_d && !origin_q;
  end

  // Render and frame-detect registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_q    <= 1'b0;
      en_q     <= 1'b0;
      val_q    <= 1'b0;
      rgb_q    <= '0;
      origin_q <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      hit_q    <= hit_d;
      en_q     <= en_d;
      val_q    <= val_d;
      rgb_q    <= rgb_d;
      origin_q <= origin_d;
      tick_q   <= tick_d;
    end
  end

  // Motion state register; position only moves on an accepted frame tick.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= FWD;
      div_cnt_q   <= '0;
      step_cnt_q  <= '0;
      pos_x_q     <= HOME_X;
      pos_y_q     <= HOME_Y;
      home_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      div_cnt_q   <= div_cnt_d;
      step_cnt_q  <= step_cnt_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      home_pend_q <= home_pend_d;
    end
  end

  // Next motion state: swing forward/back, or walk home at up to DX/DY per tick.
  always_comb begin
    logic       advance;
    logic       home_req;
    logic       take_return;
    logic [9:0] dist_x, ret_x;
    logic [8:0] dist_y, ret_y;

    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    step_cnt_d  = step_cnt_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    home_pend_d = home_pend_q;
    take_return = 1'b0;

    advance  = tick_d && motion_en;
    home_req = home_pend_q || (iHome && (state_q != RETURN));

    if (pos_x_q > HOME_X) begin
      dist_x = pos_x_q - HOME_X;
      ret_x  = pos_x_q - ((dist_x > STEP_X) ? STEP_X : dist_x);
    end else begin
      dist_x = HOME_X - pos_x_q;
      ret_x  = pos_x_q + ((dist_x > STEP_X) ? STEP_X : dist_x);
    end
    if (pos_y_q > HOME_Y) begin
      dist_y = pos_y_q - HOME_Y;
      ret_y  = pos_y_q - ((dist_y > STEP_Y) ? STEP_Y : dist_y);
    end else begin
      dist_y = HOME_Y - pos_y_q;
      ret_y  = pos_y_q + ((dist_y > STEP_Y) ? STEP_Y : dist_y);
    end

    if (advance) begin
      home_pend_d = 1'b0;
      if (home_req || (state_q == RETURN)) begin
        take_return = 1'b1;
      end else begin
        case (state_q)
          FWD: begin
            if (div_cnt_q == LAST_DIV) begin
              div_cnt_d = '0;
              pos_x_d   = pos_x_q + STEP_X;
              pos_y_d   = pos_y_q - STEP_Y;
              if (step_cnt_q == LAST_STEP) begin
                step_cnt_d = '0;
                state_d    = REV;
              end else begin
                step_cnt_d = step_cnt_q + 1'b1;
              end
            end else begin
              div_cnt_d = div_cnt_q + 1'b1;
            end
          end
          REV: begin
            if (div_cnt_q == LAST_DIV) begin
              div_cnt_d = '0;
              pos_x_d   = pos_x_q - STEP_X;
              pos_y_d   = pos_y_q + STEP_Y;
              if (step_cnt_q == LAST_STEP) begin
                step_cnt_d = '0;
                state_d    = FWD;
              end else begin
                step_cnt_d = step_cnt_q + 1'b1;
              end
            end else begin
              div_cnt_d = div_cnt_q + 1'b1;
            end
          end
          default: begin
            state_d = state_q;
          end
        endcase
      end
      if (take_return) begin
        pos_x_d    = ret_x;
        pos_y_d    = ret_y;
        div_cnt_d  = '0;
        step_cnt_d = '0;
        state_d    = ((ret_x == HOME_X) && (ret_y == HOME_Y)) ? FWD : RETURN;
      end
    end else begin
      home_pend_d = home_req;
    end
  end

  // Drive the outputs from registered state only.
  always_comb begin
    oPosX      = pos_x_q;
    oPosY      = pos_y_q;
    oFrameTick = tick_q;
    oVal       = val_q;
    oLayer     = val_q ? LAYER : '0;
    {R, G, B}  = rgb_q;
  end

endmodule

// File: tb/tb_sprite_motion_block.sv
// Randomised bench for sprite_motion_block against a behavioural model that
// derives position from the tick count and renders from box geometry.
module tb_sprite_motion_block;

  localparam int SW       = 31;
  localparam int SH       = 69;
  localparam int XI       = 280;
  localparam int YI       = 240;
  localparam int STEP_DIV = 2;
  localparam int SWING    = 3;
  localparam int DXV      = 1;
  localparam int DYV      = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable, motion_en, home;
  logic [9:0] vga_x;
  logic [8:0] vga_y;
  logic [5:0] o_layer;
  logic       o_val;
  logic [7:0] r_out, g_out, b_out;
  logic [9:0] o_pos_x;
  logic [8:0] o_pos_y;
  logic       o_frame_tick;

  int check_count = 0;
  int error_count = 0;

  sprite_motion_block #(
    .SPRITE_W(SW), .SPRITE_H(SH), .X_INIT(XI), .Y_INIT(YI),
    .LAYER(6'd1), .KEY_COLOR(24'h000000), .DX(DXV), .DY(DYV),
    .STEP_DIV(STEP_DIV), .SWING_STEPS(SWING)
  ) dut (
    .clk(clk), .reset(rst_n), .enable(enable), .motion_en(motion_en),
    .iHome(home), .iVGA_X(vga_x), .iVGA_Y(vga_y), .oLayer(o_layer),
    .oVal(o_val), .R(r_out), .G(g_out), .B(b_out), .oPosX(o_pos_x),
    .oPosY(o_pos_y), .oFrameTick(o_frame_tick)
  );

  always #5 clk = ~clk;

  // Reference model state
  int          m_x, m_y, m_ticks;
  bit          m_homing, m_pend, m_origin_prev, m_tick;
  bit          m_pend_val, m_out_val;
  logic [23:0] m_pend_rgb, m_out_rgb;

  function automatic logic [23:0] refTexel(input int a);
    if (a % 64 == 5) return 24'h000000;
    return {8'(a % 256), 8'((a / 256) % 256) ^ 8'hA5, 8'hC3};
  endfunction

  function automatic int toward(input int p, input int h, input int d);
    if (p > h) return p - (((p - h) > d) ? d : (p - h));
    return p + (((h - p) > d) ? d : (h - p));
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    m_x = XI; m_y = YI; m_ticks = 0;
    m_homing = 0; m_pend = 0; m_origin_prev = 0; m_tick = 0;
    m_pend_val = 0; m_out_val = 0; m_pend_rgb = '0; m_out_rgb = '0;
  endtask

  // One clock edge of the model, applied to the inputs about to be sampled.
  task automatic modelEdge(input int x, input int y, input bit en, input bit men, input bit hm);
    bit          hit, origin, req;
    logic [23:0] tx;
    int          steps, k, off;
    m_out_val = m_pend_val;
    if (m_pend_val) m_out_rgb = m_pend_rgb;
    hit = (x >= m_x) && (x < m_x + SW) && (y >= m_y) && (y < m_y + SH);
    tx  = hit ? refTexel(SW * (y - m_y) + (x - m_x)) : 24'h0;
    m_pend_val = en && hit && (tx != 24'h000000);
    m_pend_rgb = tx;
    origin = (x == 0) && (y == 0);
    m_tick = origin && !m_origin_prev;
    m_origin_prev = origin;
    req = m_pend || (hm && !m_homing);
    if (m_tick && men) begin
      m_pend = 0;
      if (req || m_homing) begin
        m_homing = 1;
        m_x = toward(m_x, XI, DXV);
        m_y = toward(m_y, YI, DYV);
        if (m_x == XI && m_y == YI) begin
          m_homing = 0;
          m_ticks  = 0;
        end
      end else begin
        m_ticks++;
        steps = m_ticks / STEP_DIV;
        k     = steps % (2 * SWING);
        off   = (k <= SWING) ? k : (2 * SWING - k);
        m_x   = XI + off * DXV;
        m_y   = YI - off * DYV;
      end
    end else begin
      m_pend = req;
    end
  endtask

  // Drive one cycle of inputs (from a negedge), then compare after the edge.
  task automatic applyStimulus(input int x, input int y, input bit en, input bit men, input bit hm);
    vga_x = x[9:0]; vga_y = y[8:0];
    enable = en; motion_en = men; home = hm;
    modelEdge(x, y, en, men, hm);
    @(posedge clk);
    @(negedge clk);
    checkOutput("oVal",       32'(o_val),                 32'(m_out_val));
    checkOutput("rgb",        32'({r_out, g_out, b_out}), 32'(m_out_rgb));
    checkOutput("oLayer",     32'(o_layer),               m_out_val ? 32'd1 : 32'd0);
    checkOutput("oPosX",      32'(o_pos_x),               32'(m_x));
    checkOutput("oPosY",      32'(o_pos_y),               32'(m_y));
    checkOutput("oFrameTick", 32'(o_frame_tick),          32'(m_tick));
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int tick_seen;
    rst_n = 1'b0; enable = 1'b0; motion_en = 1'b0; home = 1'b0;
    vga_x = 10'd5; vga_y = 9'd5;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("resetVal",   32'(o_val),                 32'd0);
    checkOutput("resetRgb",   32'({r_out, g_out, b_out}), 32'd0);
    checkOutput("resetLayer", 32'(o_layer),               32'd0);
    checkOutput("resetTick",  32'(o_frame_tick),          32'd0);
    checkOutput("resetPosX",  32'(o_pos_x),               32'd280);
    checkOutput("resetPosY",  32'(o_pos_y),               32'd240);
    rst_n = 1'b1;

    // Stationary render: corner, both edge misses, far corner, key colour.
    applyStimulus(280, 240, 1, 0, 0);
    applyStimulus(279, 240, 1, 0, 0);
    checkOutput("rom0", 32'({r_out, g_out, b_out}), 32'h00A5C3);
    applyStimulus(311, 240, 1, 0, 0);
    applyStimulus(310, 308, 1, 0, 0);
    applyStimulus(285, 240, 1, 0, 0);
    checkOutput("rom2138", 32'({r_out, g_out, b_out}), 32'h5AADC3);
    applyStimulus(5, 5, 1, 0, 0);
    checkOutput("keyHoldVal", 32'(o_val), 32'd0);
    checkOutput("keyHoldRgb", 32'({r_out, g_out, b_out}), 32'h5AADC3);
    applyStimulus(300, 250, 0, 0, 0);
    applyStimulus(5, 5, 1, 0, 0);

    // Oscillation over 12 frames.
    for (int f = 0; f < 12; f++) begin
      applyStimulus(0, 0, 1, 1, 0);
      if (f == 5) begin
        checkOutput("swingPeakX", 32'(o_pos_x), 32'd283);
        checkOutput("swingPeakY", 32'(o_pos_y), 32'd237);
      end
      applyStimulus(3, 1, 1, 1, 0);
    end
    checkOutput("swingEndX", 32'(o_pos_x), 32'd280);

    // Dwelling at the origin yields a single tick.
    tick_seen = 0;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(0, 0, 1, 0, 0);
      tick_seen += int'(o_frame_tick);
    end
    checkOutput("dwellTicks", 32'(tick_seen), 32'd1);
    applyStimulus(3, 1, 1, 1, 0);

    // Home request after two forward steps.
    for (int f = 0; f < 4; f++) begin
      applyStimulus(0, 0, 1, 1, 0);
      applyStimulus(3, 1, 1, 1, 0);
    end
    checkOutput("preHomeX", 32'(o_pos_x), 32'd282);
    applyStimulus(3, 1, 1, 1, 1);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("homeStep1X", 32'(o_pos_x), 32'd281);
    checkOutput("homeStep1Y", 32'(o_pos_y), 32'd239);
    applyStimulus(3, 1, 1, 1, 0);
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("homeDoneX", 32'(o_pos_x), 32'd280);
    checkOutput("homeDoneY", 32'(o_pos_y), 32'd240);
    for (int f = 0; f < 2; f++) begin
      applyStimulus(3, 1, 1, 1, 0);
      applyStimulus(0, 0, 1, 1, 0);
    end
    checkOutput("afterHomeX", 32'(o_pos_x), 32'd281);

    // Asynchronous reset while a pixel is being shown.
    applyStimulus(281, 239, 1, 0, 0);
    applyStimulus(282, 240, 1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncVal",  32'(o_val),                 32'd0);
    checkOutput("asyncRgb",  32'({r_out, g_out, b_out}), 32'd0);
    checkOutput("asyncPosX", 32'(o_pos_x),               32'd280);
    checkOutput("asyncPosY", 32'(o_pos_y),               32'd240);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(280, 240, 1, 0, 0);
    applyStimulus(5, 5, 1, 0, 0);
    applyStimulus(5, 5, 1, 0, 0);

    // Randomised traffic around the sprite with frames, enables and homing.
    for (int i = 0; i < 3000; i++) begin
      int rx, ry;
      int sel;
      sel = int'($urandom_range(0, 99));
      if (sel < 5) begin
        rx = 0; ry = 0;
      end else if (sel < 15) begin
        rx = int'($urandom_range(0, 1023));
        ry = int'($urandom_range(0, 511));
      end else begin
        rx = 270 + int'($urandom_range(0, 49));
        ry = 230 + int'($urandom_range(0, 89));
      end
      applyStimulus(rx, ry, $urandom_range(0, 9) < 8, $urandom_range(0, 99) < 85,
                    $urandom_range(0, 99) < 2);
    end

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
